// File: rtl/sequence_generator_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package sequence_generator_pkg;

  // Transmitter FSM states; S_GAP is only reachable when SEQ_GEN_GAP_EN is defined.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } seq_gen_state_t;

  // Pattern recognised by the matching sequence_detector (bit 0 is sent first).
  localparam logic [11:0] SEQ_DEFAULT_PATTERN = 12'b1110_1101_1011;

  // Width of a counter that must index n positions (at least one bit).
  function automatic int seq_cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: latches a W-bit pattern on start and shifts it
// out LSB first, one bit per clock, repeating the frame repeat_i extra times.
// Optional feature macro: SEQ_GEN_GAP_EN inserts GAP idle cycles between
// repeated frames; without it frames are sent back-to-back.
module sequence_generator
  import sequence_generator_pkg::*;
#(
  parameter int             W               = 12,
  parameter logic [W-1:0]   DEFAULT_PATTERN = W'(SEQ_DEFAULT_PATTERN),
  parameter int             GAP             = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start_i,
  input  logic         use_default_i,
  input  logic [W-1:0] pattern_i,
  input  logic [7:0]   repeat_i,
  output logic         x_o,
  output logic         x_valid_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int            CW       = seq_cnt_width(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  // Reject parameter values outside the supported range at elaboration.
  if (W < 2 || W > 32 || GAP < 1 || GAP > 15) begin : g_bad_param
    $error("sequence_generator: W must be 2..32 and GAP 1..15");
  end

  seq_gen_state_t state_r;
  logic [W-1:0]   pattern_r;    // copy used to reload repeated frames
  logic [W-1:0]   shift_r;      // bits still to be sent in the current frame
  logic [CW-1:0]  bit_cnt_r;    // index of the bit currently on x_o
  logic [7:0]     frame_cnt_r;  // frames remaining after the current one
  logic [W-1:0]   load_pattern_s;

`ifdef SEQ_GEN_GAP_EN
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  logic [3:0] gap_cnt_r;
`endif

  // Pattern to latch when a start request is accepted.
  always_comb begin
    load_pattern_s = pattern_i;
    if (use_default_i) begin
      load_pattern_s = DEFAULT_PATTERN;
    end else begin
      load_pattern_s = pattern_i;
    end
  end

  // Transmitter FSM with registered serial outputs. x_o is loaded with the
  // bit to be shown in the following cycle, so bit 0 appears one cycle after
  // the start edge and the shift register always holds the remaining bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      pattern_r   <= '0;
      shift_r     <= '0;
      bit_cnt_r   <= '0;
      frame_cnt_r <= 8'd0;
      x_o         <= 1'b0;
      x_valid_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
`ifdef SEQ_GEN_GAP_EN
      gap_cnt_r   <= 4'd0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_i) begin
            state_r     <= S_SEND;
            pattern_r   <= load_pattern_s;
            shift_r     <= {1'b0, load_pattern_s[W-1:1]};
            bit_cnt_r   <= '0;
            frame_cnt_r <= repeat_i;
            x_o         <= load_pattern_s[0];
            x_valid_o   <= 1'b1;
            busy_o      <= 1'b1;
          end else begin
            x_o         <= 1'b0;
            x_valid_o   <= 1'b0;
            busy_o      <= 1'b0;
          end
        end

        S_SEND: begin
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_r <= '0;
            if (frame_cnt_r == 8'd0) begin
              state_r   <= S_IDLE;
              x_o       <= 1'b0;
              x_valid_o <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              frame_cnt_r <= frame_cnt_r - 8'd1;
`ifdef SEQ_GEN_GAP_EN
              state_r     <= S_GAP;
              gap_cnt_r   <= 4'd0;
              x_o         <= 1'b0;
              x_valid_o   <= 1'b0;
`else
              shift_r     <= {1'b0, pattern_r[W-1:1]};
              x_o         <= pattern_r[0];
              x_valid_o   <= 1'b1;
`endif
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CW'(1);
            shift_r   <= {1'b0, shift_r[W-1:1]};
            x_o       <= shift_r[0];
            x_valid_o <= 1'b1;
          end
        end

`ifdef SEQ_GEN_GAP_EN
        S_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            state_r   <= S_SEND;
            shift_r   <= {1'b0, pattern_r[W-1:1]};
            x_o       <= pattern_r[0];
            x_valid_o <= 1'b1;
          end else begin
            gap_cnt_r <= gap_cnt_r + 4'd1;
            x_o       <= 1'b0;
            x_valid_o <= 1'b0;
          end
        end
`endif

        default: begin
          state_r   <= S_IDLE;
          x_o       <= 1'b0;
          x_valid_o <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Directed, table-driven bench for sequence_generator (W=12, GAP=3).
module tb_sequence_generator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic        use_default_i;
  logic [11:0] pattern_i;
  logic [7:0]  repeat_i;
  logic        x_o;
  logic        x_valid_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_GEN_GAP_EN
  localparam int TB_GAP = 3;
`else
  localparam int TB_GAP = 0;
`endif

  typedef struct {
    string       name;
    logic [11:0] pattern;
    logic        use_def;
    logic [7:0]  rpt;
    logic [11:0] exp_bits;   // bit k = k-th transmitted bit
  } vec_t;

  vec_t vecs [7];

  sequence_generator #(.W(12), .GAP(3)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (start_i),
    .use_default_i (use_default_i),
    .pattern_i     (pattern_i),
    .repeat_i      (repeat_i),
    .x_o           (x_o),
    .x_valid_o     (x_valid_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a transfer and check every output cycle up to and after done_o.
  // glitch_at >= 0 pulses start_i with a different request during frame 0.
  task automatic send_frames(input string name, input logic [11:0] pat, input logic ud,
                             input logic [7:0] rpt, input logic [11:0] exp_bits,
                             input int glitch_at);
    logic [11:0] got;
    start_i       = 1'b1;
    pattern_i     = pat;
    use_default_i = ud;
    repeat_i      = rpt;
    step();
    start_i       = 1'b0;
    pattern_i     = ~pat;
    use_default_i = ~ud;
    repeat_i      = 8'h07;
    for (int f = 0; f <= int'(rpt); f++) begin
      got = 12'h000;
      for (int k = 0; k < 12; k++) begin
        if (f == 0 && k == glitch_at) begin
          start_i   = 1'b1;
          pattern_i = 12'hFFF;
          repeat_i  = 8'd5;
        end else begin
          start_i   = 1'b0;
        end
        got[k] = x_o;
        check({name, " busy/valid/done in frame"}, {29'd0, busy_o, x_valid_o, done_o}, 32'b110);
        step();
      end
      check({name, " frame bits"}, {20'd0, got}, {20'd0, exp_bits});
      if (f < int'(rpt)) begin
        for (int g = 0; g < TB_GAP; g++) begin
          check({name, " gap cycle"}, {28'd0, busy_o, x_valid_o, x_o, done_o}, 32'b1000);
          step();
        end
      end
    end
    start_i = 1'b0;
    check({name, " done cycle"}, {28'd0, busy_o, x_valid_o, done_o, x_o}, 32'b0010);
    step();
    check({name, " after done"}, {28'd0, busy_o, x_valid_o, done_o, x_o}, 32'b0000);
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{"a5c single",   12'hA5C, 1'b0, 8'd0, 12'hA5C};
    vecs[1] = '{"default",      12'h000, 1'b1, 8'd0, 12'hEDB};
    vecs[2] = '{"all ones x2",  12'hFFF, 1'b0, 8'd1, 12'hFFF};
    vecs[3] = '{"lsb only",     12'h001, 1'b0, 8'd0, 12'h001};
    vecs[4] = '{"msb only x3",  12'h800, 1'b0, 8'd2, 12'h800};
    vecs[5] = '{"default x3",   12'h555, 1'b1, 8'd2, 12'hEDB};
    vecs[6] = '{"alternating",  12'hAAA, 1'b0, 8'd0, 12'hAAA};

    reset_n       = 1'b0;
    start_i       = 1'b0;
    use_default_i = 1'b0;
    pattern_i     = 12'h000;
    repeat_i      = 8'd0;
    step();
    step();
    check("reset outputs", {28'd0, x_o, x_valid_o, busy_o, done_o}, 32'b0000);
    reset_n = 1'b1;
    step();
    check("idle outputs", {28'd0, x_o, x_valid_o, busy_o, done_o}, 32'b0000);

    // Table-driven vectors
    for (int i = 0; i < 7; i++) begin
      send_frames(vecs[i].name, vecs[i].pattern, vecs[i].use_def, vecs[i].rpt,
                  vecs[i].exp_bits, -1);
      step();
    end

    // Start while busy: stream unchanged, single done_o
    send_frames("start while busy", 12'h0F0, 1'b0, 8'd0, 12'h0F0, 3);
    step();
    step();
    check("ignored start stays idle", {30'd0, busy_o, x_valid_o}, 32'b00);

    // Reset in the middle of a frame (while the 5th bit is on x_o)
    start_i   = 1'b1;
    pattern_i = 12'hA5C;
    repeat_i  = 8'd3;
    step();
    start_i   = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("bit 4 before reset", {31'd0, x_o}, 32'd1);
    reset_n = 1'b0;
    step();
    check("reset mid-frame", {29'd0, x_valid_o, busy_o, done_o}, 32'b000);
    reset_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 60; c++) begin
      if (done_o) done_seen++;
      step();
    end
    check("no done after abort", done_seen, 0);
    send_frames("restart after reset", 12'h3C5, 1'b0, 8'd0, 12'h3C5, -1);

    // Back-to-back starts: start_i held high, period W+1
    start_i       = 1'b1;
    pattern_i     = 12'h93A;
    use_default_i = 1'b0;
    repeat_i      = 8'd0;
    step();
    for (int f = 0; f < 3; f++) begin
      logic [11:0] got;
      got = 12'h000;
      for (int k = 0; k < 12; k++) begin
        got[k] = x_o;
        check("b2b valid", {30'd0, x_valid_o, done_o}, 32'b10);
        step();
      end
      check("b2b frame bits", {20'd0, got}, 32'h93A);
      check("b2b done cycle", {29'd0, busy_o, x_valid_o, done_o}, 32'b001);
      if (f == 2) start_i = 1'b0;
      step();
    end
    check("b2b final idle", {29'd0, busy_o, x_valid_o, done_o}, 32'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
# sequence_generator

Serial pattern transmitter: on a start request it latches a W-bit pattern and shifts it out one bit per clock, LSB first, optionally repeating the frame. It drives the serial stream consumed by `sequence_detector`. With the default pattern and parameters, a looped-back `sequence_detector` asserts `det_o` once per frame. It sits at the stimulus/transmit end of the serial link.

## Interface
- `W`, 12: pattern/frame width in bits (2..32)
- `DEFAULT_PATTERN`, 12'b1110_1101_1011: pattern loaded when `use_default_i` is high
- `GAP`, 2: idle cycles between repeated frames (used only with `SEQ_GEN_GAP_EN`; 1..15)
- `clk` input 1: single clock, all logic on rising edge
- `reset_n` input 1: synchronous, active-low reset
- `start_i` input 1: start request, sampled only in IDLE
- `use_default_i` input 1: at start, load `DEFAULT_PATTERN` instead of `pattern_i`
- `pattern_i` input W: pattern to send; bit 0 is transmitted first
- `repeat_i` input 8: extra frames; total frames = `repeat_i`+1
- `x_o` output 1: serial data
- `x_valid_o` output 1: high in every cycle that `x_o` carries a pattern bit
- `busy_o` output 1: high from the cycle after start is accepted until the return to IDLE
- `done_o` output 1: one-cycle pulse after the last bit of the last frame

## Operation
- FSM states: IDLE, SEND, GAP (GAP exists only with `SEQ_GEN_GAP_EN`).
- IDLE: `x_o`=0, `x_valid_o`=0, `busy_o`=0. When `start_i`=1, latch the pattern (`pattern_i`, or `DEFAULT_PATTERN` when `use_default_i`=1) into the shift register, latch `repeat_i` into the frame counter, clear the bit counter, and go to SEND.
- SEND: `x_o` = shift_reg[0] and `x_valid_o`=1. Each cycle, shift right and increment the bit counter (width $clog2(W)).
- After bit W-1:
  - If the frame counter is 0: go to IDLE and pulse `done_o`.
  - Otherwise: decrement the frame counter, reload the shift register from the latched pattern copy (not from `pattern_i`), and go to SEND, or to GAP when gap is enabled.
- GAP: `x_o`=0, `x_valid_o`=0, `busy_o`=1 for exactly `GAP` cycles, then SEND.
- `start_i` outside IDLE is ignored with no queuing. `pattern_i`, `use_default_i` and `repeat_i` are don't-care after acceptance.
- `done_o` and an accepted new `start_i` may coincide: IDLE is entered in the `done_o` cycle, so a start sampled in that cycle is accepted.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE. `x_o`, `x_valid_o`, `busy_o` and `done_o` are 0, and all counters and registers are cleared. Reset during SEND or GAP aborts the frame with no `done_o`.
- Start sampled at edge E0: bit k of frame 0 is on `x_o` during the cycle after edge E0+k (k = 0..W-1). The first bit appears 1 cycle after acceptance, and all outputs are registered.
- Frame length is W cycles. Without gap, frames are back-to-back: frame n starts n·W cycles after frame 0. With gap, frame n starts n·(W+GAP) cycles after frame 0.
- `done_o` is high for the single cycle immediately after the last bit, with `busy_o`=0 in that cycle.
- `repeat_i`=255 sends 256 frames. The frame counter does not wrap.

## Configuration
- `SEQ_GEN_GAP_EN` defined: the GAP state and `GAP` parameter are active, and frames are separated by `GAP` low, invalid cycles.
- Not defined: no GAP state, frames are back-to-back, and `GAP` is ignored.

## Structure
- Package `sequence_generator_pkg`:
  - state enum `seq_gen_state_t` (IDLE, SEND, GAP)
  - `SEQ_DEFAULT_PATTERN` constant
  - counter-width localparam helper
- Single module. No sub-module is needed; the shift register is inline.

## Test plan
- Reset mid-frame: start, then drop `reset_n` at the 5th bit. `x_valid_o`, `busy_o` and `done_o` are 0 at the next edge, no `done_o` pulse occurs, and a new start works normally.
- Single frame: `pattern_i`=12'hA5C, `repeat_i`=0. `x_o` carries 0,0,1,1,1,0,1,0,0,1,0,1 on 12 consecutive valid cycles, then `done_o` pulses once and `busy_o` falls.
- Loopback to `sequence_detector`:
  - `use_default_i`=1, `repeat_i`=2, gap disabled; detector reset driven by ~`reset_n`.
  - `det_o` pulses exactly 3 times, 12 cycles apart, the first 2 cycles after the last bit of frame 0.
- Gap enabled (`SEQ_GEN_GAP_EN`, `GAP`=3, `repeat_i`=1): 12 valid cycles, 3 cycles with `x_valid_o`=0, 12 valid cycles, then `done_o`. The total from start to `done_o` is 28 cycles.
- Start while busy: pulse `start_i` with a different pattern during SEND. The output stream is unchanged and only one `done_o` occurs.
- Back-to-back start: hold `start_i`=1 continuously with `repeat_i`=0. Frames repeat every W+1 cycles (one idle cycle, the `done_o` cycle, between frames), and `done_o` pulses once per frame.
